// File: rtl/bip_ctrl_pipe.sv
// BIP control unit: program counter, registered IR with valid bit, opcode decode,
// absolute branches with one-slot flush and sticky HALT. Optional macro: BIP_CTRL_CYCLE_COUNT_EN.
module bip_ctrl_pipe #(
  parameter int PC_WIDTH     = 11,
  parameter int INSTR_WIDTH  = 16,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [INSTR_WIDTH-1:0]                instruction,
  input  logic                                  acc_zero,
  output logic [PC_WIDTH-1:0]                   pc,
  output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0]   operand,
  output logic [1:0]                            sel_a,
  output logic                                  sel_b,
  output logic                                  op,
  output logic                                  wr_acc,
  output logic                                  wr_ram,
  output logic                                  rd_ram,
`ifdef BIP_CTRL_CYCLE_COUNT_EN
  output logic [31:0]                           cycle_count,
`endif
  output logic                                  halted
);

  localparam int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(10);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q;
  logic [INSTR_WIDTH-1:0]   ir_q;
  logic                     ir_valid_q;
  logic                     active, taken, halt_now, advance;
  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [OPERAND_WIDTH-1:0] ir_operand;

  assign opcode     = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign ir_operand = ir_q[OPERAND_WIDTH-1:0];
  assign pc         = pc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Decode only a valid IR while running; anything else behaves as a NOP.
  always_comb begin
    state_d  = state_q;
    operand  = '0;
    sel_a    = 2'd0;
    sel_b    = 1'b0;
    op       = 1'b0;
    wr_acc   = 1'b0;
    wr_ram   = 1'b0;
    rd_ram   = 1'b0;
    taken    = 1'b0;
    halt_now = 1'b0;
    active   = ir_valid_q && (state_q == ST_RUN);
    if (active) begin
      operand = ir_operand;
      case (opcode)
        OP_HLT:  begin halt_now = 1'b1; state_d = ST_HALT; end
        OP_STO:  wr_ram = 1'b1;
        OP_LD:   begin rd_ram = 1'b1; wr_acc = 1'b1; sel_a = 2'd0; end
        OP_LDI:  begin wr_acc = 1'b1; sel_a = 2'd1; end
        OP_ADD:  begin rd_ram = 1'b1; wr_acc = 1'b1; sel_a = 2'd2; end
        OP_ADDI: begin wr_acc = 1'b1; sel_a = 2'd2; sel_b = 1'b1; end
        OP_SUB:  begin rd_ram = 1'b1; wr_acc = 1'b1; sel_a = 2'd2; op = 1'b1; end
        OP_SUBI: begin wr_acc = 1'b1; sel_a = 2'd2; sel_b = 1'b1; op = 1'b1; end
        OP_BEQ:  taken = acc_zero;
        OP_BNE:  taken = !acc_zero;
        OP_JMP:  taken = 1'b1;
        default: ;
      endcase
    end
    halted  = (state_q == ST_HALT) || halt_now;
    advance = (state_q == ST_RUN) && !halt_now;
  end

  // A taken branch redirects pc and invalidates the word fetched behind it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else if (advance) begin
      ir_q       <= instruction;
      ir_valid_q <= !taken;
      pc_q       <= taken ? PC_WIDTH'(ir_operand) : pc_q + PC_WIDTH'(1);
    end
  end

`ifdef BIP_CTRL_CYCLE_COUNT_EN
  // Counts only advancing edges, so the edge that enters HALT is not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        cycle_count <= 32'd0;
    else if (advance) cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule
